// File: rtl/pit_axi_lite_if.sv
// AXI4-Lite bus bundle for the PIT register slave.
// The master modport drives requests; the slave modport drives ready/response.
interface pit_axi_lite_if #(
   parameter int unsigned AddrWidth = 4,
   parameter int unsigned DataWidth = 32
) ();
   logic [AddrWidth-1:0]   awaddr;
   logic [2:0]             awprot;
   logic                   awvalid;
   logic                   awready;
   logic [DataWidth-1:0]   wdata;
   logic [DataWidth/8-1:0] wstrb;
   logic                   wvalid;
   logic                   wready;
   logic [1:0]             bresp;
   logic                   bvalid;
   logic                   bready;
   logic [AddrWidth-1:0]   araddr;
   logic [2:0]             arprot;
   logic                   arvalid;
   logic                   arready;
   logic [DataWidth-1:0]   rdata;
   logic [1:0]             rresp;
   logic                   rvalid;
   logic                   rready;

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      output araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      input  araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/pit_axi_lite_slave.sv
// AXI4-Lite slave with a programmable interval timer (CTRL/PERIOD/COUNT/STATUS).
// Optional prescaler in CTRL[15:8] is enabled by defining PIT_PRESCALER_EN.
module pit_axi_lite_slave #(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic          s00_axi_aclk,
   input  logic          s00_axi_aresetn,
   pit_axi_lite_if.slave s00_axi,
   output logic          irq
);

   typedef logic [C_S_AXI_DATA_WIDTH-1:0] word_t;

   localparam logic [1:0] RegCtrl   = 2'd0;
   localparam logic [1:0] RegPeriod = 2'd1;
   localparam logic [1:0] RegCount  = 2'd2;
   localparam logic [1:0] RegStatus = 2'd3;

   function automatic word_t apply_strb(input word_t old_v, input word_t new_v,
                                        input logic [3:0] strb);
      word_t res;
      res = old_v;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
      end
      return res;
   endfunction

   logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr;
   logic [C_S_AXI_ADDR_WIDTH-1:0] araddr;
   logic                          wr_fire, rd_fire, tick, expire;
   logic                          aw_wready_q, aw_wready_d;
   logic                          bvalid_q, bvalid_d;
   logic                          arready_q, arready_d;
   logic                          rvalid_q, rvalid_d;
   word_t                         rdata_q, rdata_d;
   word_t                         period_q, period_d;
   word_t                         count_q, count_d;
   word_t                         rd_word;
   logic                          en_q, en_d;
   logic                          ie_q, ie_d;
   logic                          ar_q, ar_d;
   logic                          exp_q, exp_d;
   logic                          irq_q, irq_d;
   logic [7:0]                    presc_rd;
   logic                          unused_sigs;
`ifdef PIT_PRESCALER_EN
   logic [7:0]                    presc_q, presc_d;
   logic [7:0]                    psc_q, psc_d;
`endif

   assign awaddr = s00_axi.awaddr;
   assign araddr = s00_axi.araddr;
   assign unused_sigs = ^{awaddr[1:0], araddr[1:0], s00_axi.awprot, s00_axi.arprot};

`ifdef PIT_PRESCALER_EN
   assign presc_rd = presc_q;
`else
   assign presc_rd = 8'h00;
`endif

   // Each channel only takes a new request when it is fully idle.
   assign wr_fire = s00_axi.awvalid & s00_axi.wvalid & ~bvalid_q & ~aw_wready_q;
   assign rd_fire = s00_axi.arvalid & ~rvalid_q & ~arready_q;

   always_comb begin
      rd_word = '0;
      unique case (araddr[3:2])
         RegCtrl:   rd_word = {16'h0000, presc_rd, 5'b00000, ar_q, ie_q, en_q};
         RegPeriod: rd_word = period_q;
         RegCount:  rd_word = count_q;
         RegStatus: rd_word = {{(C_S_AXI_DATA_WIDTH-1){1'b0}}, exp_q};
         default:   rd_word = '0;
      endcase
   end

   always_comb begin
      aw_wready_d = wr_fire;
      bvalid_d    = bvalid_q ? ~s00_axi.bready : aw_wready_q;
      arready_d   = rd_fire;
      rvalid_d    = rvalid_q ? ~s00_axi.rready : arready_q;
      rdata_d     = rd_fire ? rd_word : rdata_q;
   end

   always_comb begin
      en_d     = en_q;
      ie_d     = ie_q;
      ar_d     = ar_q;
      exp_d    = exp_q;
      period_d = period_q;
      count_d  = count_q;
`ifdef PIT_PRESCALER_EN
      presc_d  = presc_q;
      psc_d    = psc_q;
      tick     = en_q && (psc_q == presc_q);
      if (en_q) psc_d = tick ? 8'd0 : psc_q + 8'd1;
`else
      tick     = en_q;
`endif
      expire   = tick && (count_q == word_t'(1));

      if (tick) begin
         if (count_q > word_t'(1)) begin
            count_d = count_q - word_t'(1);
         end else if (expire) begin
            if (ar_q) begin
               count_d = period_q;
            end else begin
               count_d = '0;
               en_d    = 1'b0;
            end
         end
      end

      // CPU writes land after the timer update so they win over a hardware EN clear.
      if (wr_fire) begin
         unique case (awaddr[3:2])
            RegCtrl: begin
               if (s00_axi.wstrb[0]) begin
                  en_d = s00_axi.wdata[0];
                  ie_d = s00_axi.wdata[1];
                  ar_d = s00_axi.wdata[2];
               end
`ifdef PIT_PRESCALER_EN
               if (s00_axi.wstrb[1]) presc_d = s00_axi.wdata[15:8];
`endif
               if (!en_q && en_d) begin
                  count_d = period_q;
`ifdef PIT_PRESCALER_EN
                  psc_d   = 8'd0;
`endif
               end
            end
            RegPeriod: period_d = apply_strb(period_q, s00_axi.wdata, s00_axi.wstrb);
            RegCount:  ;
            RegStatus: if (s00_axi.wstrb[0] && s00_axi.wdata[0]) exp_d = 1'b0;
            default:   ;
         endcase
      end

      if (expire) exp_d = 1'b1;
      irq_d = exp_d & ie_d;
   end

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         aw_wready_q <= 1'b0;
         bvalid_q    <= 1'b0;
         arready_q   <= 1'b0;
         rvalid_q    <= 1'b0;
         rdata_q     <= '0;
         period_q    <= '0;
         count_q     <= '0;
         en_q        <= 1'b0;
         ie_q        <= 1'b0;
         ar_q        <= 1'b0;
         exp_q       <= 1'b0;
         irq_q       <= 1'b0;
`ifdef PIT_PRESCALER_EN
         presc_q     <= 8'd0;
         psc_q       <= 8'd0;
`endif
      end else begin
         aw_wready_q <= aw_wready_d;
         bvalid_q    <= bvalid_d;
         arready_q   <= arready_d;
         rvalid_q    <= rvalid_d;
         rdata_q     <= rdata_d;
         period_q    <= period_d;
         count_q     <= count_d;
         en_q        <= en_d;
         ie_q        <= ie_d;
         ar_q        <= ar_d;
         exp_q       <= exp_d;
         irq_q       <= irq_d;
`ifdef PIT_PRESCALER_EN
         presc_q     <= presc_d;
         psc_q       <= psc_d;
`endif
      end
   end

   assign s00_axi.awready = aw_wready_q;
   assign s00_axi.wready  = aw_wready_q;
   assign s00_axi.bresp   = 2'b00;
   assign s00_axi.bvalid  = bvalid_q;
   assign s00_axi.arready = arready_q;
   assign s00_axi.rdata   = rdata_q;
   assign s00_axi.rresp   = 2'b00;
   assign s00_axi.rvalid  = rvalid_q;
   assign irq             = irq_q;

endmodule

// File: tb/tb_pit_axi_lite_slave.sv
// Directed bench for pit_axi_lite_slave: register access, timer modes, handshake stalls, reset.
module tb_pit_axi_lite_slave;

   logic clk = 1'b0;
   logic rst_n;
   logic irq;

   always #5 clk = ~clk;

   pit_axi_lite_if bus ();

   pit_axi_lite_slave dut (
      .s00_axi_aclk    (clk),
      .s00_axi_aresetn (rst_n),
      .s00_axi         (bus),
      .irq             (irq)
   );

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   int unsigned cyc = 0;
   int unsigned pulse_cnt = 0;
   int unsigned last_wr_cyc = 0;
   logic        irq_at_acc;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.awready && bus.wready) pulse_cnt <= pulse_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic wait_awready(input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (bus.awready) begin
            ok = 1'b1;
            break;
         end
      end
      check_eq(tag, 32'(ok), 32'd1);
   endtask

   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
      int unsigned p0;
      @(posedge clk); #1;
      bus.awaddr  = addr;
      bus.wdata   = data;
      bus.wstrb   = strb;
      bus.awvalid = 1'b1;
      bus.wvalid  = 1'b1;
      bus.bready  = 1'b0;
      p0 = pulse_cnt;
      wait_awready("wr_accept");
      check_eq("wr_wready", 32'(bus.wready), 32'd1);
      last_wr_cyc = cyc;
      irq_at_acc  = irq;
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      bus.bready  = 1'b1;
      @(posedge clk); #1;
      check_eq("wr_bvalid", 32'(bus.bvalid), 32'd1);
      check_eq("wr_awready_drop", 32'(bus.awready), 32'd0);
      check_eq("wr_bresp", 32'(bus.bresp), 32'd0);
      @(posedge clk); #1;
      check_eq("wr_bvalid_drop", 32'(bus.bvalid), 32'd0);
      check_eq("wr_pulses", pulse_cnt - p0, 32'd1);
      bus.bready = 1'b0;
   endtask

   task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
      bit ok = 1'b0;
      @(posedge clk); #1;
      bus.araddr  = addr;
      bus.arvalid = 1'b1;
      bus.rready  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (bus.arready) begin
            ok = 1'b1;
            break;
         end
      end
      check_eq("rd_accept", 32'(ok), 32'd1);
      bus.arvalid = 1'b0;
      bus.rready  = 1'b1;
      @(posedge clk); #1;
      check_eq("rd_rvalid", 32'(bus.rvalid), 32'd1);
      check_eq("rd_rresp", 32'(bus.rresp), 32'd0);
      data = bus.rdata;
      @(posedge clk); #1;
      check_eq("rd_rvalid_drop", 32'(bus.rvalid), 32'd0);
      bus.rready = 1'b0;
   endtask

   task automatic read_chk(input string tag, input logic [3:0] addr, input logic [31:0] exp);
      logic [31:0] d;
      axi_read(addr, d);
      check_eq(tag, d, exp);
   endtask

   task automatic wait_irq(input int max, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(posedge clk); #1;
         if (irq) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned wc, prev;
      bit          seen, stable;
      logic [31:0] d0;

      bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
      bus.wdata  = '0; bus.wstrb  = '0; bus.wvalid  = 1'b0; bus.bready = 1'b0;
      bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_outputs", 32'({bus.awready, bus.wready, bus.bvalid, bus.arready,
                                   bus.rvalid, irq, bus.bresp, bus.rresp}), 32'd0);
      check_eq("rst_rdata", bus.rdata, 32'd0);
      rst_n = 1'b1;
      read_chk("rst_ctrl", 4'h0, 32'd0);
      read_chk("rst_period", 4'h4, 32'd0);

      // Register readback
      axi_write(4'h0, 32'h1, 4'hF);
      axi_write(4'h4, 32'h2, 4'hF);
      axi_write(4'h8, 32'h3, 4'hF);
      axi_write(4'hC, 32'h4, 4'hF);
      read_chk("rb_ctrl", 4'h0, 32'h1);
      read_chk("rb_period", 4'h4, 32'h2);
      read_chk("rb_count", 4'h8, 32'h0);
      read_chk("rb_status", 4'hC, 32'h0);
      axi_write(4'h4, 32'hFFFF_FFFF, 4'b0010);
      read_chk("rb_period_strb", 4'h4, 32'h0000_FF02);
      axi_write(4'h0, 32'h0, 4'hF);

      // One-shot
      axi_write(4'h4, 32'd10, 4'hF);
      axi_write(4'h0, 32'h3, 4'hF);
      wc = last_wr_cyc;
      wait_irq(40, seen);
      check_eq("os_irq_seen", 32'(seen), 32'd1);
      check_eq("os_latency", cyc - wc, 32'd10);
      read_chk("os_status", 4'hC, 32'h1);
      read_chk("os_count", 4'h8, 32'h0);
      read_chk("os_ctrl", 4'h0, 32'h2);
      check_eq("os_irq_held", 32'(irq), 32'd1);
      axi_write(4'hC, 32'h1, 4'hF);
      check_eq("os_irq_clear_next", 32'(irq_at_acc), 32'd0);
      read_chk("os_status_clr", 4'hC, 32'h0);

      // Auto-reload
      axi_write(4'h4, 32'd5, 4'hF);
      axi_write(4'h0, 32'h7, 4'hF);
      prev = last_wr_cyc;
      for (int k = 0; k < 4; k++) begin
         wait_irq(20, seen);
         check_eq("ar_irq_seen", 32'(seen), 32'd1);
         check_eq("ar_period", cyc - prev, 32'd5);
         prev = cyc;
         axi_write(4'hC, 32'h1, 4'hF);
      end
      axi_write(4'h0, 32'h0, 4'hF);
      axi_write(4'hC, 32'h1, 4'hF);
      axi_write(4'h4, 32'h0, 4'hF);
      axi_write(4'h0, 32'h7, 4'hF);
      repeat (30) @(posedge clk);
      #1;
      check_eq("p0_no_irq", 32'(irq), 32'd0);
      read_chk("p0_status", 4'hC, 32'h0);
      read_chk("p0_count", 4'h8, 32'h0);
      read_chk("p0_ctrl", 4'h0, 32'h7);
      axi_write(4'h0, 32'h0, 4'hF);

      // Handshake stress: AW early, B stalled, second write blocked while bvalid
      wc = pulse_cnt;
      @(posedge clk); #1;
      bus.awaddr = 4'h4; bus.wdata = 32'hA5A5_0001; bus.wstrb = 4'hF;
      bus.awvalid = 1'b1; bus.wvalid = 1'b0; bus.bready = 1'b0;
      stable = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         if (bus.awready) stable = 1'b0;
      end
      check_eq("st_aw_waits_w", 32'(stable), 32'd1);
      bus.wvalid = 1'b1;
      wait_awready("st_accept1");
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      @(posedge clk); #1;
      check_eq("st_bvalid", 32'(bus.bvalid), 32'd1);
      bus.wdata = 32'hDEAD_BEEF; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      stable = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
         if (!bus.bvalid || bus.bresp != 2'b00 || bus.awready) stable = 1'b0;
      end
      check_eq("st_b_stall_stable", 32'(stable), 32'd1);
      bus.bready = 1'b1;
      wait_awready("st_accept2");
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      @(posedge clk); #1;
      check_eq("st_bvalid2", 32'(bus.bvalid), 32'd1);
      @(posedge clk); #1;
      check_eq("st_bvalid2_drop", 32'(bus.bvalid), 32'd0);
      bus.bready = 1'b0;
      check_eq("st_pulses", pulse_cnt - wc, 32'd2);
      read_chk("st_period", 4'h4, 32'hDEAD_BEEF);

      // Concurrent read and write of PERIOD with R stalled
      @(posedge clk); #1;
      bus.araddr = 4'h4; bus.arvalid = 1'b1; bus.rready = 1'b0;
      bus.awaddr = 4'h4; bus.wdata = 32'h1234_5678; bus.wstrb = 4'hF;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
      wait_awready("cc_accept");
      check_eq("cc_arready_same", 32'(bus.arready), 32'd1);
      bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      @(posedge clk); #1;
      check_eq("cc_rvalid", 32'(bus.rvalid), 32'd1);
      d0 = bus.rdata;
      check_eq("cc_old_value", d0, 32'hDEAD_BEEF);
      stable = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
         if (!bus.rvalid || bus.rdata !== d0) stable = 1'b0;
      end
      check_eq("cc_r_stall_stable", 32'(stable), 32'd1);
      bus.rready = 1'b1;
      @(posedge clk); #1;
      check_eq("cc_rvalid_drop", 32'(bus.rvalid), 32'd0);
      bus.rready = 1'b0; bus.bready = 1'b0;
      read_chk("cc_new_period", 4'h4, 32'h1234_5678);

      // W1C on the expiry edge
      axi_write(4'h4, 32'd4, 4'hF);
      axi_write(4'h0, 32'h3, 4'hF);
      wc = last_wr_cyc;
      axi_write(4'hC, 32'h1, 4'hF);
      check_eq("col_on_expiry_edge", last_wr_cyc - wc, 32'd4);
      check_eq("col_irq_kept", 32'(irq_at_acc), 32'd1);
      read_chk("col_status", 4'hC, 32'h1);
      read_chk("col_ctrl", 4'h0, 32'h2);
      axi_write(4'hC, 32'h1, 4'hF);
      read_chk("col_status_clr", 4'hC, 32'h0);

`ifdef PIT_PRESCALER_EN
      axi_write(4'h4, 32'd4, 4'hF);
      axi_write(4'h0, 32'h0000_0303, 4'hF);
      wc = last_wr_cyc;
      wait_irq(60, seen);
      check_eq("ps_irq_seen", 32'(seen), 32'd1);
      check_eq("ps_latency", cyc - wc, 32'd16);
      read_chk("ps_ctrl", 4'h0, 32'h0000_0302);
      axi_write(4'hC, 32'h1, 4'hF);
      axi_write(4'h0, 32'h0, 4'hF);
`else
      axi_write(4'h0, 32'h0000_FF00, 4'hF);
      read_chk("nops_ctrl", 4'h0, 32'h0);
`endif

      // Reset mid-run with COUNT=3 and a pending write response
      axi_write(4'h4, 32'd10, 4'hF);
      axi_write(4'h0, 32'h1, 4'hF);
      @(posedge clk); #1;
      bus.awaddr = 4'h4; bus.wdata = 32'd10; bus.wstrb = 4'hF;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
      @(posedge clk); #1;
      check_eq("rr_accept", 32'(bus.awready), 32'd1);
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rr_bvalid_pending", 32'(bus.bvalid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("rr_async_outputs", 32'({bus.awready, bus.wready, bus.bvalid, bus.arready,
                                        bus.rvalid, irq, bus.bresp, bus.rresp}), 32'd0);
      check_eq("rr_async_rdata", bus.rdata, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check_eq("rr_no_late_bvalid", 32'(bus.bvalid), 32'd0);
      read_chk("rr_ctrl", 4'h0, 32'h0);
      read_chk("rr_period", 4'h4, 32'h0);
      read_chk("rr_count", 4'h8, 32'h0);
      read_chk("rr_status", 4'hC, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
